mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Memory-side responder for the MMU's ibus/dbus memory ports: accepts the instruction-fetch and data requests that bypass the cache (uncached / C=2,7 accesses) and services them on one single-port asynchronous SRAM with programmable wait states.
- Returns data plus data_ready pulses that line up with the core's combined pause rule: all requests sampled together get their ready in the same cycle.

Parameters:
- WAIT_STATES, 2, extra SRAM cycles per access; each access lasts WAIT_STATES+1 cycles.
- ADDR_W, 20, SRAM word-address width; the word address is phy_addr[ADDR_W+1:2].

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- i_en_i  input  1  instruction read request; held by requester until ready.
- i_addr_i  input  32  instruction physical address.
- i_data_ready_o  output  1  one-cycle pulse; i_data_o valid in that cycle.
- i_data_o  output  32  fetched word.
- d_en_i  input  1  data request; held by requester until ready.
- d_addr_i  input  32  data physical address.
- d_wr_i  input  1  1=write, 0=read.
- d_bytesel_i  input  4  byte lanes; used for writes only.
- d_data_i  input  32  write data, lane-aligned as given.
- d_data_ready_o  output  1  one-cycle pulse.
- d_data_o  output  32  read word; 0 after a write.
- sram_addr_o  output  ADDR_W  SRAM word address.
- sram_data_o  output  32  SRAM write data.
- sram_data_i  input  32  SRAM read data.
- sram_ce_n_o  output  1  chip enable, active-low.
- sram_oe_n_o  output  1  output enable, active-low.
- sram_we_n_o  output  1  write enable, active-low.
- sram_be_n_o  output  4  byte enables, active-low.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_i=0):
  - State goes to IDLE; wait counter is cleared.
  - Readies, data outputs, sram_addr_o and sram_data_o are 0.
  - sram_ce_n_o, sram_oe_n_o and sram_we_n_o are 1; sram_be_n_o is 4'hF; busy_o is 0.
- FSM states: IDLE, D_ACC, I_ACC, DONE. All SRAM outputs are registered.
- IDLE:
  - Sample i_en_i and d_en_i into pend_i and pend_d.
  - If pend_d is set, go to D_ACC. Otherwise, if pend_i is set, go to I_ACC. If neither is set, stay in IDLE.
  - Data has priority because it is the older instruction.
- D_ACC / I_ACC:
  - Counter runs 0..WAIT_STATES; ce_n=0 for the whole access.
  - Address and data are captured from the inputs on entry and held constant through the access.
  - Read:
    - oe_n=0, be_n=0000.
    - sram_data_i is captured into the result register on the edge that ends the last access cycle.
  - Write (D only):
    - be_n=~d_bytesel_i; sram_data_o=d_data_i.
    - we_n=0 for counter 0..WAIT_STATES-1 and 1 in the last cycle (hold). When WAIT_STATES=0, we_n=0 for the single cycle.
    - d_data_o is cleared to 0.
  - After D_ACC ends: go to I_ACC if pend_i is set, otherwise go to DONE.
  - After I_ACC ends: go to DONE.
- DONE (1 cycle):
  - SRAM is idle (ce_n, oe_n, we_n = 1).
  - i_data_ready_o=pend_i and d_data_ready_o=pend_d, asserted together for exactly one cycle; the FSM then returns to IDLE.
- Latency, with en first high in cycle 0:
  - Single access: ready in cycle WAIT_STATES+2.
  - Both ports: ready in cycle 2*WAIT_STATES+3.
- i_data_o and d_data_o hold their value until overwritten by the next access (or cleared by a write / reset).
- Back-to-back: IDLE re-samples en the cycle after DONE, so continuously high en with changing addresses forms a new transaction each time.
- Requests arriving while busy are ignored until the next IDLE.
- en dropped mid-access: the access still completes and ready is still pulsed for the sampled port. A write still commits.
- Reset mid-access: SRAM controls deassert immediately; no ready pulse is produced.
- Addresses above ADDR_W+2 bits are truncated (aliasing); this is not an error.

Test Plan:
- Reset check: hold rst_i=0 mid-run -> ce_n/oe_n/we_n=1, be_n=F, both readies 0, busy_o=0.
- I read, WAIT_STATES=2: i_en=1, i_addr=0x00000040, sram_data_i=0xDEADBEEF -> sram_addr=0x10, oe_n low cycles 1-3, i_data_ready pulse cycle 4 with i_data_o=0xDEADBEEF, d_data_ready stays 0.
- D byte write: d_addr=0x104, d_wr=1, bytesel=0001, d_data=0x55 -> sram_addr=0x41, be_n=1110, we_n low cycles 1-2, high cycle 3, d_data_ready cycle 4, d_data_o=0.
- Simultaneous requests: d read 0x8 (sram 0x11111111) + i read 0xC (0x22222222) -> D_ACC cycles 1-3, I_ACC 4-6, both readies in cycle 7 only, with correct data.
- Async reset in cycle 2 of an access -> SRAM controls high same cycle, no ready pulses, IDLE after release.
- WAIT_STATES=0 back-to-back: i_en held high, address changes after each ready -> ready every 3 cycles, each returning its own address' word.

Source files
------------

// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Memory-side responder for the MMU's uncached instruction and data ports.
//   It serves both ports from one single-port asynchronous SRAM that needs
//   WAIT_STATES extra cycles per access. When both ports are sampled
//   together, the data access runs first and the instruction access follows.
//   Both readies are then pulsed in the same DONE cycle.
//
// Ports
//   clk_i, rst_i           clock (rising edge), async active-low reset
//   i_en_i, i_addr_i       instruction read request (held until ready)
//   i_data_ready_o         one-cycle ready pulse for the instruction port
//   i_data_o               fetched word, held until the next fetch
//   d_en_i, d_addr_i       data request (held until ready)
//   d_wr_i, d_bytesel_i    write flag and byte lanes (lanes used for writes)
//   d_data_i               lane-aligned write data
//   d_data_ready_o         one-cycle ready pulse for the data port
//   d_data_o               read word (cleared to 0 by a write)
//   sram_*                 registered asynchronous-SRAM interface (active-low controls)
//   busy_o                 high whenever the FSM is not in IDLE
module mem_bus_responder #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_en_i,
    input  logic [31:0]       i_addr_i,
    output logic              i_data_ready_o,
    output logic [31:0]       i_data_o,
    input  logic              d_en_i,
    input  logic [31:0]       d_addr_i,
    input  logic              d_wr_i,
    input  logic [3:0]        d_bytesel_i,
    input  logic [31:0]       d_data_i,
    output logic              d_data_ready_o,
    output logic [31:0]       d_data_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_data_o,
    input  logic [31:0]       sram_data_i,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic [3:0]        sram_be_n_o,
    output logic              busy_o
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, DONE} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
    logic              pend_i, pend_i_nx;
    logic              pend_d, pend_d_nx;
    logic              wr_q, wr_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [31:0]       wdata_nx;
    logic              ce_n_nx, oe_n_nx, we_n_nx;
    logic [3:0]        be_n_nx;
    logic [31:0]       i_data_nx, d_data_nx;
    logic              start_d, start_i;

    // Only bits [ADDR_W+1:2] of each address reach the SRAM. Higher bits
    // alias, and the byte offset is irrelevant for word accesses.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr_i, d_addr_i};

    // The readies decode the registered state, so each pulse lasts exactly
    // one cycle. Both readies rise together for the ports sampled in IDLE.
    assign i_data_ready_o = (state == DONE) && pend_i;
    assign d_data_ready_o = (state == DONE) && pend_d;
    assign busy_o         = (state != IDLE);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        state_nx  = state;
        cnt_nx    = cnt;
        pend_i_nx = pend_i;
        pend_d_nx = pend_d;
        wr_nx     = wr_q;
        addr_nx   = sram_addr_o;
        wdata_nx  = sram_data_o;
        ce_n_nx   = 1'b1;
        oe_n_nx   = 1'b1;
        we_n_nx   = 1'b1;
        be_n_nx   = 4'hF;
        i_data_nx = i_data_o;
        d_data_nx = d_data_o;
        start_d   = 1'b0;
        start_i   = 1'b0;
        cnt_inc   = cnt + CNT_W'(1);

        case (state)
            IDLE: begin
                pend_i_nx = i_en_i;
                pend_d_nx = d_en_i;
                // The data request belongs to the older instruction, so it goes first.
                if (d_en_i)      start_d = 1'b1;
                else if (i_en_i) start_i = 1'b1;
            end
            D_ACC: begin
                if (cnt == CNT_LAST) begin
                    d_data_nx = wr_q ? 32'h0 : sram_data_i;
                    if (pend_i) start_i  = 1'b1;
                    else        state_nx = DONE;
                end else begin
                    cnt_nx  = cnt_inc;
                    ce_n_nx = 1'b0;
                    oe_n_nx = sram_oe_n_o;
                    be_n_nx = sram_be_n_o;
                    // Release we_n for the final cycle so that address and data
                    // are held while the write strobe rises.
                    we_n_nx = !(wr_q && (cnt_inc != CNT_LAST));
                end
            end
            I_ACC: begin
                if (cnt == CNT_LAST) begin
                    i_data_nx = sram_data_i;
                    state_nx  = DONE;
                end else begin
                    cnt_nx  = cnt_inc;
                    ce_n_nx = 1'b0;
                    oe_n_nx = 1'b0;
                    be_n_nx = 4'h0;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Access launch: address, data and controls are captured here
        // and then held for the whole access.
        if (start_d) begin
            state_nx = D_ACC;
            cnt_nx   = '0;
            wr_nx    = d_wr_i;
            addr_nx  = d_addr_i[ADDR_W+1:2];
            ce_n_nx  = 1'b0;
            if (d_wr_i) begin
                we_n_nx  = 1'b0;
                be_n_nx  = ~d_bytesel_i;
                wdata_nx = d_data_i;
            end else begin
                oe_n_nx = 1'b0;
                be_n_nx = 4'h0;
            end
        end
        if (start_i) begin
            state_nx = I_ACC;
            cnt_nx   = '0;
            wr_nx    = 1'b0;
            addr_nx  = i_addr_i[ADDR_W+1:2];
            ce_n_nx  = 1'b0;
            oe_n_nx  = 1'b0;
            be_n_nx  = 4'h0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            pend_i      <= 1'b0;
            pend_d      <= 1'b0;
            wr_q        <= 1'b0;
            sram_addr_o <= '0;
            sram_data_o <= 32'h0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
            sram_be_n_o <= 4'hF;
            i_data_o    <= 32'h0;
            d_data_o    <= 32'h0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            pend_i      <= pend_i_nx;
            pend_d      <= pend_d_nx;
            wr_q        <= wr_nx;
            sram_addr_o <= addr_nx;
            sram_data_o <= wdata_nx;
            sram_ce_n_o <= ce_n_nx;
            sram_oe_n_o <= oe_n_nx;
            sram_we_n_o <= we_n_nx;
            sram_be_n_o <= be_n_nx;
            i_data_o    <= i_data_nx;
            d_data_o    <= d_data_nx;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder. Instance A uses WAIT_STATES=2 and instance
// B uses WAIT_STATES=0. Each instance drives a small behavioural
// asynchronous SRAM. Expected ready data and ready cycles are queued when a
// request is issued. A negedge monitor pops the queues and compares them
// against every ready pulse.
module tb_mem_bus_responder;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_a_n, rst_b_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    exp_t qa_i[$], qa_d[$], qb_i[$], qb_d[$];

    // Instance A signals
    logic        a_i_en, a_d_en, a_d_wr, a_i_rdy, a_d_rdy;
    logic [31:0] a_i_addr, a_d_addr, a_d_wdata, a_i_data, a_d_data;
    logic [3:0]  a_d_bytesel, a_be_n;
    logic [19:0] a_sram_addr;
    logic [31:0] a_sram_wdata, a_sram_rdata;
    logic        a_ce_n, a_oe_n, a_we_n, a_busy;

    // Instance B signals
    logic        b_i_en, b_d_en, b_d_wr, b_i_rdy, b_d_rdy;
    logic [31:0] b_i_addr, b_d_addr, b_d_wdata, b_i_data, b_d_data;
    logic [3:0]  b_d_bytesel, b_be_n;
    logic [19:0] b_sram_addr;
    logic [31:0] b_sram_wdata, b_sram_rdata;
    logic        b_ce_n, b_oe_n, b_we_n, b_busy;

    mem_bus_responder #(.WAIT_STATES(2), .ADDR_W(20)) dut_a (
        .clk_i(clk), .rst_i(rst_a_n),
        .i_en_i(a_i_en), .i_addr_i(a_i_addr), .i_data_ready_o(a_i_rdy), .i_data_o(a_i_data),
        .d_en_i(a_d_en), .d_addr_i(a_d_addr), .d_wr_i(a_d_wr), .d_bytesel_i(a_d_bytesel),
        .d_data_i(a_d_wdata), .d_data_ready_o(a_d_rdy), .d_data_o(a_d_data),
        .sram_addr_o(a_sram_addr), .sram_data_o(a_sram_wdata), .sram_data_i(a_sram_rdata),
        .sram_ce_n_o(a_ce_n), .sram_oe_n_o(a_oe_n), .sram_we_n_o(a_we_n),
        .sram_be_n_o(a_be_n), .busy_o(a_busy)
    );

    mem_bus_responder #(.WAIT_STATES(0), .ADDR_W(20)) dut_b (
        .clk_i(clk), .rst_i(rst_b_n),
        .i_en_i(b_i_en), .i_addr_i(b_i_addr), .i_data_ready_o(b_i_rdy), .i_data_o(b_i_data),
        .d_en_i(b_d_en), .d_addr_i(b_d_addr), .d_wr_i(b_d_wr), .d_bytesel_i(b_d_bytesel),
        .d_data_i(b_d_wdata), .d_data_ready_o(b_d_rdy), .d_data_o(b_d_data),
        .sram_addr_o(b_sram_addr), .sram_data_o(b_sram_wdata), .sram_data_i(b_sram_rdata),
        .sram_ce_n_o(b_ce_n), .sram_oe_n_o(b_oe_n), .sram_we_n_o(b_we_n),
        .sram_be_n_o(b_be_n), .busy_o(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAMs: asynchronous read; byte-lane writes while ce_n and we_n are low.
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic        load_en_a, load_en_b;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    assign a_sram_rdata = mem_a[a_sram_addr[7:0]];
    assign b_sram_rdata = mem_b[b_sram_addr[7:0]];

    always @(posedge clk) begin
        if (load_en_a) mem_a[load_addr] <= load_data;
        else if (!a_ce_n && !a_we_n)
            for (int k = 0; k < 4; k++)
                if (!a_be_n[k]) mem_a[a_sram_addr[7:0]][8*k +: 8] <= a_sram_wdata[8*k +: 8];
    end

    always @(posedge clk) begin
        if (load_en_b) mem_b[load_addr] <= load_data;
        else if (!b_ce_n && !b_we_n)
            for (int k = 0; k < 4; k++)
                if (!b_be_n[k]) mem_b[b_sram_addr[7:0]][8*k +: 8] <= b_sram_wdata[8*k +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load(input bit sel_b, input logic [7:0] addr, input logic [31:0] data);
        load_addr = addr;
        load_data = data;
        load_en_a = !sel_b;
        load_en_b = sel_b;
        @(posedge clk); #1;
        load_en_a = 1'b0;
        load_en_b = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (a_i_rdy) begin
            if (qa_i.size() == 0) check("a_i unexpected ready", 32'd1, 32'd0);
            else begin
                e = qa_i.pop_front();
                check("a_i data", a_i_data, e.data);
                check("a_i ready cycle", cyc, e.cyc);
            end
        end
        if (a_d_rdy) begin
            if (qa_d.size() == 0) check("a_d unexpected ready", 32'd1, 32'd0);
            else begin
                e = qa_d.pop_front();
                check("a_d data", a_d_data, e.data);
                check("a_d ready cycle", cyc, e.cyc);
            end
        end
        if (b_i_rdy) begin
            if (qb_i.size() == 0) check("b_i unexpected ready", 32'd1, 32'd0);
            else begin
                e = qb_i.pop_front();
                check("b_i data", b_i_data, e.data);
                check("b_i ready cycle", cyc, e.cyc);
            end
        end
        if (b_d_rdy) begin
            if (qb_d.size() == 0) check("b_d unexpected ready", 32'd1, 32'd0);
            else begin
                e = qb_d.pop_front();
                check("b_d data", b_d_data, e.data);
                check("b_d ready cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int t0;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        load_en_a = 1'b0; load_en_b = 1'b0; load_addr = '0; load_data = '0;
        a_i_en = 0; a_i_addr = 0; a_d_en = 0; a_d_addr = 0; a_d_wr = 0; a_d_bytesel = 0; a_d_wdata = 0;
        b_i_en = 0; b_i_addr = 0; b_d_en = 0; b_d_addr = 0; b_d_wr = 0; b_d_bytesel = 0; b_d_wdata = 0;

        @(posedge clk); #1;
        load(1'b0, 8'h10, 32'hDEADBEEF);
        load(1'b0, 8'h41, 32'hAABBCCDD);
        load(1'b0, 8'h02, 32'h11111111);
        load(1'b0, 8'h03, 32'h22222222);
        for (int k = 0; k < 4; k++) load(1'b1, 8'(k), 32'hB0000000 + 32'(k));
        load(1'b1, 8'h05, 32'h0000BEEF);

        // Reset state
        @(negedge clk);
        check("rst ce_n", a_ce_n, 1);
        check("rst oe_n", a_oe_n, 1);
        check("rst we_n", a_we_n, 1);
        check("rst be_n", a_be_n, 4'hF);
        check("rst busy", a_busy, 0);
        check("rst i_rdy", a_i_rdy, 0);
        check("rst d_rdy", a_d_rdy, 0);
        check("rst sram_addr", a_sram_addr, 0);
        check("rst sram_data", a_sram_wdata, 0);
        check("rst i_data", a_i_data, 0);
        check("rst d_data", a_d_data, 0);
        @(posedge clk); #1;
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(posedge clk); #1;

        // Instruction read, WAIT_STATES=2
        a_i_en = 1; a_i_addr = 32'h40; t0 = cyc;
        qa_i.push_back('{32'hDEADBEEF, t0 + 4});
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 0) check("t1 idle busy", a_busy, 0);
            else if (c <= 3) begin
                check("t1 oe_n", a_oe_n, 0);
                check("t1 ce_n", a_ce_n, 0);
                check("t1 sram_addr", a_sram_addr, 20'h10);
                check("t1 busy", a_busy, 1);
            end else begin
                check("t1 done ce_n", a_ce_n, 1);
                check("t1 done oe_n", a_oe_n, 1);
            end
        end
        @(posedge clk); #1; a_i_en = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t1 i_data hold", a_i_data, 32'hDEADBEEF);

        // Simultaneous data read + instruction read
        @(posedge clk); #1;
        a_d_en = 1; a_d_wr = 0; a_d_addr = 32'h8;
        a_i_en = 1; a_i_addr = 32'hC; t0 = cyc;
        qa_d.push_back('{32'h11111111, t0 + 7});
        qa_i.push_back('{32'h22222222, t0 + 7});
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 3) check("t3 d addr", a_sram_addr, 20'h2);
            if (c >= 4 && c <= 6) check("t3 i addr", a_sram_addr, 20'h3);
            if (c >= 1 && c <= 6) check("t3 ce_n", a_ce_n, 0);
        end
        @(posedge clk); #1; a_d_en = 0; a_i_en = 0;

        // Data byte write (also clears d_data_o from the previous read)
        @(posedge clk); #1;
        a_d_en = 1; a_d_wr = 1; a_d_addr = 32'h104; a_d_bytesel = 4'b0001; a_d_wdata = 32'h55; t0 = cyc;
        qa_d.push_back('{32'h0, t0 + 4});
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                check("t2 sram_addr", a_sram_addr, 20'h41);
                check("t2 be_n", a_be_n, 4'hE);
                check("t2 wdata", a_sram_wdata, 32'h55);
                check("t2 oe_n", a_oe_n, 1);
                check("t2 we_n", a_we_n, (c == 3) ? 32'd1 : 32'd0);
            end
        end
        @(posedge clk); #1; a_d_en = 0; a_d_wr = 0;
        @(negedge clk);
        check("t2 mem merged", mem_a[8'h41], 32'hAABBCC55);
        @(posedge clk); #1;
        a_i_en = 1; a_i_addr = 32'h104; t0 = cyc;
        qa_i.push_back('{32'hAABBCC55, t0 + 4});
        repeat (5) @(posedge clk); #1; a_i_en = 0;

        // Enable dropped mid-write: the write still commits and ready still pulses
        @(posedge clk); #1;
        a_d_en = 1; a_d_wr = 1; a_d_addr = 32'h200; a_d_bytesel = 4'hF; a_d_wdata = 32'h12345678; t0 = cyc;
        qa_d.push_back('{32'h0, t0 + 4});
        repeat (2) @(posedge clk); #1; a_d_en = 0; a_d_wr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5 write committed", mem_a[8'h80], 32'h12345678);

        // Asynchronous reset in cycle 2 of an access
        @(posedge clk); #1;
        a_i_en = 1; a_i_addr = 32'h40; t0 = cyc;
        @(posedge clk);
        @(negedge clk);
        check("t4 ce_n before reset", a_ce_n, 0);
        @(posedge clk); #1;
        rst_a_n = 1'b0; a_i_en = 0;
        #1;
        check("t4 ce_n", a_ce_n, 1);
        check("t4 oe_n", a_oe_n, 1);
        check("t4 we_n", a_we_n, 1);
        check("t4 be_n", a_be_n, 4'hF);
        check("t4 busy", a_busy, 0);
        check("t4 i_rdy", a_i_rdy, 0);
        check("t4 i_data", a_i_data, 0);
        @(posedge clk); #1; rst_a_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t4 idle after release", a_busy, 0);
        @(posedge clk); #1;
        a_i_en = 1; a_i_addr = 32'hC; t0 = cyc;
        qa_i.push_back('{32'h22222222, t0 + 4});
        repeat (5) @(posedge clk); #1; a_i_en = 0;

        // WAIT_STATES=0: back-to-back fetches with en held high
        @(posedge clk); #1;
        b_i_en = 1; b_i_addr = 32'h0; t0 = cyc;
        for (int k = 0; k < 4; k++) qb_i.push_back('{32'hB0000000 + 32'(k), t0 + 3*k + 2});
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("b2b sram_addr", b_sram_addr, 20'(k));
            check("b2b oe_n", b_oe_n, 0);
            @(posedge clk);
            @(posedge clk); #1;
            if (k == 3) b_i_en = 0;
            else        b_i_addr = 32'(4*(k+1));
        end

        // WAIT_STATES=0 partial write, then data read-back
        @(posedge clk); #1;
        b_d_en = 1; b_d_wr = 1; b_d_addr = 32'h14; b_d_bytesel = 4'b1100; b_d_wdata = 32'hCAFE0000; t0 = cyc;
        qb_d.push_back('{32'h0, t0 + 2});
        @(posedge clk);
        @(negedge clk);
        check("b wr we_n", b_we_n, 0);
        check("b wr be_n", b_be_n, 4'b0011);
        @(posedge clk);
        @(negedge clk);
        check("b wr done we_n", b_we_n, 1);
        @(posedge clk); #1; b_d_en = 0; b_d_wr = 0;
        @(posedge clk); #1;
        b_d_en = 1; b_d_addr = 32'h14; t0 = cyc;
        qb_d.push_back('{32'hCAFEBEEF, t0 + 2});
        repeat (3) @(posedge clk); #1; b_d_en = 0;

        repeat (6) @(posedge clk);
        @(negedge clk);
        check("qa_i drained", qa_i.size(), 0);
        check("qa_d drained", qa_d.size(), 0);
        check("qb_i drained", qb_i.size(), 0);
        check("qb_d drained", qb_d.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
